// File: rtl/aileron_pkg.sv
// Shared types, angle limits and the valve decode equations for the aileron sequencer.
package aileron_pkg;

    typedef logic signed [3:0] ang_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        MOVE = 2'd2
    } state_t;

    localparam ang_t ANG_MIN = -4'sd7;
    localparam ang_t ANG_MAX = 4'sd7;

    // Returns {v1e, v2e, v1d, v2d}.
    function automatic logic [3:0] decode(input ang_t a);
        logic b3, b2, b1, b0;
        {b3, b2, b1, b0} = a;
        decode[3] = b3 & (b0 | b1 | b2);
        decode[2] = ~b2 | (~b1 & ~b0);
        decode[1] = (~b3 & b2) | (~b2 & b0) | (~b2 & b1) | (b2 & ~b1 & ~b0);
        decode[0] = b2;
    endfunction

    function automatic ang_t clamp(input ang_t a);
        if (a < ANG_MIN) begin
            clamp = ANG_MIN;
        end else if (a > ANG_MAX) begin
            clamp = ANG_MAX;
        end else begin
            clamp = a;
        end
    endfunction

    function automatic logic signed [4:0] diff5(input ang_t a, input ang_t b);
        diff5 = $signed({a[3], a}) - $signed({b[3], b});
    endfunction

    function automatic logic signed [1:0] sgn(input logic signed [4:0] d);
        if (d == 5'sd0) begin
            sgn = 2'sb00;
        end else if (d[4]) begin
            sgn = 2'sb11;
        end else begin
            sgn = 2'sb01;
        end
    endfunction

endpackage

// File: rtl/aileron_valve_dec.sv
// Combinational valve decoder: angle -> {v1e, v2e, v1d, v2d}.
module aileron_valve_dec
    import aileron_pkg::*;
(
    input  logic signed [3:0] ang,
    output logic [3:0]        valves
);

    assign valves = decode(ang);

endmodule

// File: rtl/aileron_ctrl.sv
// Aileron slew sequencer: accepts a target angle, steps cur_ang toward it with dead time on reversal.
// Optional macro AILERON_CTRL_CENTER_EN adds a center_req input that retargets to 0.
module aileron_ctrl
    import aileron_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef AILERON_CTRL_CENTER_EN
    input  logic              center_req,
`endif
    input  logic              cmd_valid,
    input  logic signed [3:0] cmd_ang,
    output logic              cmd_ready,
    output logic signed [3:0] cur_ang,
    output logic              busy,
    output logic              done,
    output logic              v1e,
    output logic              v2e,
    output logic              v1d,
    output logic              v2d
);

    localparam int CNT_MAX = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // state | meaning
    // IDLE  | at target, ready for a command
    // DEAD  | all valves closed before a direction reversal
    // MOVE  | stepping cur_ang one unit every STEP_CYCLES clocks
    state_t             state, state_nxt;
    ang_t               cur_nxt, target, target_nxt, new_tgt;
    logic signed [1:0]  last_dir, last_dir_nxt, dir, new_dir;
    logic signed [4:0]  diff, new_diff;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               arrive, arrive_nxt, launch;
    logic [3:0]         dec_valves, valve_d, valves;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_ang  <= '0;
            target   <= '0;
            last_dir <= '0;
            cnt      <= '0;
            arrive   <= 1'b0;
            done     <= 1'b0;
            valves   <= 4'b0100;
        end else begin
            state    <= state_nxt;
            cur_ang  <= cur_nxt;
            target   <= target_nxt;
            last_dir <= last_dir_nxt;
            cnt      <= cnt_nxt;
            arrive   <= arrive_nxt;
            done     <= arrive;
            valves   <= valve_d;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur_ang;
        target_nxt   = target;
        last_dir_nxt = last_dir;
        cnt_nxt      = cnt;
        arrive_nxt   = 1'b0;

        diff    = diff5(target, cur_ang);
        dir     = sgn(diff);
        new_tgt = clamp(cmd_ang);
        launch  = (state == IDLE) && cmd_valid;
`ifdef AILERON_CTRL_CENTER_EN
        // Centering wins over a simultaneous handshake, from any state.
        if (center_req) begin
            new_tgt = '0;
            launch  = 1'b1;
        end
`endif
        new_diff = diff5(new_tgt, cur_ang);
        new_dir  = sgn(new_diff);

        if (launch) begin
            target_nxt = new_tgt;
            cnt_nxt    = '0;
            if (new_diff == 5'sd0) begin
                state_nxt  = IDLE;
                arrive_nxt = 1'b1;
            end else if (last_dir != 2'sb00 && new_dir != last_dir) begin
                state_nxt = DEAD;
            end else begin
                state_nxt = MOVE;
            end
        end else begin
            unique case (state)
                IDLE: ;
                DEAD: begin
                    if (cnt == CNT_W'(DEAD_CYCLES - 1)) begin
                        state_nxt = MOVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                MOVE: begin
                    if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
                        cnt_nxt      = '0;
                        cur_nxt      = cur_ang + $signed({{2{dir[1]}}, dir});
                        last_dir_nxt = dir;
                        if (cur_nxt == target) begin
                            state_nxt  = IDLE;
                            arrive_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    aileron_valve_dec u_dec (
        .ang    (cur_nxt),
        .valves (dec_valves)
    );

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        valve_d   = (state_nxt == DEAD) ? 4'b0000 : dec_valves;
    end

    assign {v1e, v2e, v1d, v2d} = valves;

endmodule

// File: tb/tb_aileron_ctrl.sv
// Self-checking bench for aileron_ctrl: directed latency/boundary checks plus randomized traffic
// compared every cycle against a time-budget model of the slew sequencer.
module tb_aileron_ctrl;

    localparam int STEP = 4;
    localparam int DEAD = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic signed [3:0] cmd_ang = '0;
    logic              cmd_ready, busy, done, v1e, v2e, v1d, v2d;
    logic signed [3:0] cur_ang;
`ifdef AILERON_CTRL_CENTER_EN
    logic              center_req = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: where the actuator is, where it is going, and how much time remains.
    int m_cur, m_tgt, m_last, m_dir, m_dead_left, m_step_left;
    bit m_moving, m_pend, m_done;

    always #5 clk = ~clk;

    aileron_ctrl #(.STEP_CYCLES(STEP), .DEAD_CYCLES(DEAD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AILERON_CTRL_CENTER_EN
        .center_req(center_req),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ang   (cmd_ang),
        .cmd_ready (cmd_ready),
        .cur_ang   (cur_ang),
        .busy      (busy),
        .done      (done),
        .v1e       (v1e),
        .v2e       (v2e),
        .v1d       (v1d),
        .v2d       (v2d)
    );

    function automatic logic [3:0] ref_valves(input int a);
        logic [3:0] b;
        logic e1, e2, d1, d2;
        b  = 4'(a);
        e1 = b[3] & (b[0] | b[1] | b[2]);
        e2 = ~b[2] | (~b[1] & ~b[0]);
        d1 = (~b[3] & b[2]) | (~b[2] & b[0]) | (~b[2] & b[1]) | (b[2] & ~b[1] & ~b[0]);
        d2 = b[2];
        return {e1, e2, d1, d2};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cur = 0; m_tgt = 0; m_last = 0; m_dir = 0;
            m_dead_left = 0; m_step_left = 0;
            m_moving = 0; m_pend = 0; m_done = 0;
        end else begin
            m_done = m_pend;
            m_pend = 0;
            if (!m_moving) begin
                if (cmd_valid) begin
                    m_tgt = (int'(cmd_ang) < -7) ? -7 : int'(cmd_ang);
                    if (m_tgt == m_cur) begin
                        m_pend = 1;
                    end else begin
                        m_dir       = (m_tgt > m_cur) ? 1 : -1;
                        m_dead_left = (m_last != 0 && m_dir != m_last) ? DEAD : 0;
                        m_step_left = STEP;
                        m_moving    = 1;
                    end
                end
            end else if (m_dead_left > 0) begin
                m_dead_left--;
            end else begin
                m_step_left--;
                if (m_step_left == 0) begin
                    m_cur       = m_cur + m_dir;
                    m_last      = m_dir;
                    m_step_left = STEP;
                    if (m_cur == m_tgt) begin
                        m_moving = 0;
                        m_pend   = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [10:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = {!m_moving, m_moving, m_done, 4'(m_cur),
                     (m_dead_left > 0) ? 4'b0000 : ref_valves(m_cur)};
            act_v = {cmd_ready, busy, done, cur_ang, v1e, v2e, v1d, v2d};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_model t=%0t got rdy,busy,done,ang,valves=%b expected %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int a, output int lat);
        cmd_valid = 1'b1;
        cmd_ang   = 4'(a);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, n, cnt_done;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ang", int'(cur_ang), 0);
        check("reset_valves", int'({v1e, v2e, v1d, v2d}), 4'b0100);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_busy_done", int'({busy, done}), 0);

        send(3, lat);
        check("lat_plus3", lat, 13);
        check("ang_plus3", int'(cur_ang), 3);
        check("valves_plus3", int'({v1e, v2e, v1d, v2d}), 4'b0110);

        send(-3, lat);
        check("lat_reverse", lat, 27);
        check("ang_minus3", int'(cur_ang), -3);
        check("valves_minus3", int'({v1e, v2e, v1d, v2d}), 4'b1001);

        send(0, lat);
        check("lat_back_to_0", lat, 15);

        send(-8, lat);
        check("lat_clamp", lat, 31);
        check("ang_clamp", int'(cur_ang), -7);
        check("valves_minus7", int'({v1e, v2e, v1d, v2d}), 4'b1110);

        send(-7, lat);
        check("lat_equal", lat, 1);

        // Mid-move reset, with a command offered while busy.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b1;
        cmd_ang   = 4'sd5;
        @(posedge clk);
        @(negedge clk);
        cmd_ang = -4'sd6;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (cur_ang !== 4'sd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_plus2", int'(cur_ang), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_ang", int'(cur_ang), 0);
        check("rst_mid_valves", int'({v1e, v2e, v1d, v2d}), 4'b0100);
        check("rst_mid_ready", int'(cmd_ready), 1);
        cnt_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) cnt_done++;
            @(negedge clk);
        end
        check("rst_mid_no_done", cnt_done, 0);

        // Random traffic: commands, offers while busy, occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_ang   = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        repeat (80) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aileron_ctrl.md
Name: aileron_ctrl

Overview:
Sequencer for the aileron valve decoder. Accepts a commanded signed 4-bit aileron angle over a valid/ready handshake and slews the actual angle toward it one unit per STEP_CYCLES clocks. Inserts a valve dead time on direction reversal. Drives the four valve lines (v1e, v2e, v1d, v2d) through the existing decode equations. Sits between flight-command logic and the valve drivers.

Parameters:
STEP_CYCLES, 4, clocks per 1-unit angle step (>=1)
DEAD_CYCLES, 2, clocks with all valves closed before a direction reversal (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  new target angle offered
cmd_ang  in  4 signed  target angle, two's complement
cmd_ready  out  1  controller idle, able to accept a command
cur_ang  out  4 signed  current actuated angle
busy  out  1  move or dead time in progress
done  out  1  one-cycle pulse when cur_ang reaches target
v1e, v2e, v1d, v2d  out  1 each  valve commands, registered

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. Reset is sampled on the clk edge only.
- Reset values: state=IDLE, cur_ang=0, target=0, last_dir=0, step counter=0, cmd_ready=1, busy=0, done=0, valves = decode(0) = v1e0 v2e1 v1d0 v2d0.
- A command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_ready = (state==IDLE). Commands offered while not ready are ignored and not queued.
- Clamp on accept: cmd_ang = -8 latches target = -7. The legal range is -7..+7.
- State IDLE:
  - On accept with target==cur_ang: stay IDLE; done=1 on the next cycle.
  - Otherwise dir = sign(target - cur_ang). If last_dir != 0 and dir != last_dir, go to DEAD; else go to MOVE.
  - Counter clears in both cases.
- State DEAD: valves forced 0000. After DEAD_CYCLES clocks go to MOVE; counter clears. cur_ang is unchanged.
- State MOVE:
  - Counter increments each clock.
  - On count == STEP_CYCLES-1: cur_ang += dir, counter clears, last_dir = dir.
  - If the new cur_ang == target, go to IDLE and pulse done for 1 cycle, the cycle after cur_ang reaches target.
- Latency, accept edge to done high: |target - cur_ang| * STEP_CYCLES + 1 cycles, plus DEAD_CYCLES on reversal.
- busy = (state != IDLE).
- Valve registers load decode(next cur_ang) every clock except in DEAD, where they load 0000. Valves therefore change on the same edge as cur_ang.
- Arithmetic: cur_ang stays in -7..+7 by construction. No wrap-around. Use 5-bit signed internally for the difference.
- Reset mid-move: everything returns to reset values on the next edge. The target is discarded.
- last_dir is retained across IDLE, so reversal detection spans commands.

Optional Feature:
Macro AILERON_CTRL_CENTER_EN.
- With it: input port center_req (1 bit) exists. When sampled high in any state, it overrides the target to 0 on that edge.
  - Direction and dead-time rules are re-evaluated from the current cur_ang: reversal goes to DEAD; already at 0 goes to IDLE and pulses done.
  - center_req has priority over a simultaneous cmd_valid accept, which is dropped.
- Without it: no center_req port. Only the handshake changes the target.

Decomposition:
- Package aileron_pkg:
  - typedef ang_t, signed 4-bit.
  - state enum {IDLE, DEAD, MOVE}.
  - constants ANG_MIN=-7, ANG_MAX=7.
  - decode function. Bits b3 = MSB … b0 = LSB:
    - v1e = b3&(b0|b1|b2)
    - v2e = ~b2 | (~b1&~b0)
    - v1d = (~b3&b2) | (~b2&b0) | (~b2&b1) | (b2&~b1&~b0)
    - v2d = b2
- Natural sub-module: aileron_valve_dec, combinational ang_t -> 4 valve bits. Instantiated once on the next-state angle.

Test Plan:
- Reset, then release with cmd_valid=0 -> cur_ang=0, valves 0100, cmd_ready=1, busy=0, done never asserts.
- From 0, accept cmd_ang=+3 -> cur_ang steps 1,2,3 every 4 clocks. Valves end at decode(3)=0110. done pulses exactly 13 cycles after accept; cmd_ready low throughout the move.
- From +3, accept -3 -> valves 0000 for 2 cycles, then 6 steps of 4 clocks. Final valves decode(-3)=1001. done at cycle 2+24+1 after accept.
- Accept cmd_ang=-8 from 0 -> target clamps to -7, final cur_ang=-7. Also: accept target equal to cur_ang -> no state change, done pulses on the next cycle.
- Assert rst_n=0 for 1 cycle mid-move (cur_ang=+2 toward +5) -> next edge cur_ang=0, valves 0100, IDLE; no done pulse. Also: offer cmd_valid while busy -> ignored.
- With AILERON_CTRL_CENTER_EN: during a move toward +5 at cur_ang=+2, center_req=1 together with cmd_valid -> DEAD for 2 cycles, then steps 1,0, done. The cmd_valid command is not applied.
